fir_stream_arbiter: RTL and testbench
=====================================

# fir_stream_arbiter

Per-packet round-robin arbiter that shares one FIR filter stream input between several AXI-Stream source channels. It grants one channel for a whole packet (up to tlast). After every packet it inserts zero-valued flush beats so the filter delay line does not leak samples between channels. A packet-length watchdog truncates runaway packets. It sits directly upstream of the FIR slave port and tags each beat with its channel id.

## Interface
Parameters:
- N_CH, 4: number of source channels (2..8).
- DATA_W, 16: sample width (signed two's complement).
- FLUSH_LEN, 15: zero beats inserted after each packet; equals the FIR tap count.
- MAX_PKT, 1024: maximum data beats per packet before forced truncation.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- s_axis_tvalid  in  N_CH  per-channel valid.
- s_axis_tlast  in  N_CH  per-channel end of packet.
- s_axis_tready  out  N_CH  per-channel ready; at most one bit high.
- m_axis_fir_tdata  out  DATA_W  sample to FIR.
- m_axis_fir_tvalid  out  1  output valid.
- m_axis_fir_tlast  out  1  last data beat of packet (real or forced).
- m_axis_fir_tready  in  1  FIR ready.
- m_axis_fir_tid  out  clog2(N_CH)  granted channel id, held through that channel's flush.
- m_axis_fir_tflush  out  1  high on flush beats.
- err_trunc  out  1  one-cycle pulse when a packet is truncated.

## Operation
States: IDLE, PASS, DROP, FLUSH.
- IDLE: s_axis_tready = 0 and m_axis_fir_tvalid = 0. If any s_axis_tvalid is high, register grant = first requesting channel searching from rr_ptr+1 modulo N_CH, set rr_ptr = grant, clear beat_cnt, go to PASS. rr_ptr resets to N_CH-1, so channel 0 wins first.
- PASS: combinational pass-through of the granted channel.
  - m_axis_fir_tdata/tvalid/tlast come from channel grant.
  - s_axis_tready[grant] = m_axis_fir_tready; all other ready bits are 0.
  - A beat transfers when valid and ready are both high; each transfer increments beat_cnt.
  - Transfer with s_axis_tlast: go to FLUSH.
  - Transfer with beat_cnt == MAX_PKT-1 and no tlast: m_axis_fir_tlast is forced high on that beat, err_trunc pulses the next cycle, go to DROP.
  - A beat that has both tlast and the limit is a normal end: no error, go to FLUSH.
- DROP: m_axis_fir_tvalid = 0 and s_axis_tready[grant] = 1. Discard beats until the granted channel's tlast transfers, then go to FLUSH.
- FLUSH: m_axis_fir_tvalid = 1, tdata = 0, tflush = 1, tlast = 0, tid = grant.
  - Count FLUSH_LEN transfers (flush_cnt), then go to IDLE.
  - All s_axis_tready bits are 0.
- tid equals grant in PASS and FLUSH.
- Arithmetic: beat_cnt is clog2(MAX_PKT+1) bits, flush_cnt is clog2(FLUSH_LEN+1) bits. No overflow is possible because both are bounded by the transitions above.

## Timing
- Reset (asynchronous, reset = 0):
  - State IDLE, rr_ptr = N_CH-1, counters 0, grant 0, err_trunc 0.
  - All outputs 0: s_axis_tready 0, m_axis_fir_tvalid 0, tdata 0, tlast 0, tid 0, tflush 0.
- Arbitration latency: 1 cycle from request in IDLE to first possible transfer in PASS.
- Packet-to-packet gap: FLUSH_LEN transfers plus 1 IDLE cycle.
- PASS adds zero latency: output valid is combinational from the input, and input ready is combinational from m_axis_fir_tready.
- Once valid is high, the output beat stays stable until it transfers (AXI-Stream rule). FLUSH beats hold valid while m_axis_fir_tready = 0.
- Reset asserted mid-packet or mid-flush: everything clears immediately and the partial packet is abandoned. Sources must restart on a packet boundary.
- Requests arriving during PASS, DROP or FLUSH are not lost; they are evaluated in the next IDLE cycle.

## Structure
- A shared package, fir_pkg, holds:
  - the state enum (IDLE, PASS, DROP, FLUSH);
  - the FIR_TAPS = 15 constant used as the FLUSH_LEN default;
  - DATA_W default 16.
- One natural sub-module: rr_priority_pick (N_CH request vector plus last pointer in, one-hot/encoded winner and any-request flag out). It is purely combinational, so it can be reused by future coefficient-bank arbiters.
- All other logic stays in the top module: FSM, counters and output muxing.

## Test plan
1. Reset, then channel 0 sends a 4-beat packet (1,2,3,4, tlast on 4) with m_axis_fir_tready = 1. Expect tid 0 and data 1..4 with tlast on 4, then 15 zero beats with tflush = 1, then IDLE.
2. Channels 1 and 3 request together from reset, each with a 2-beat packet. Expect grant order 1 then 3. Then channels 0, 1 and 3 all request after 3: expect 0, then 1, then 3 (wrap-around).
3. m_axis_fir_tready toggled 1,0,0,1 during PASS and FLUSH. Expect output data/valid/tlast held stable while stalled, no duplicated or lost beats, and flush count still exactly 15.
4. MAX_PKT = 8, channel 2 sends 12 beats with tlast on beat 12. Expect beats 1..8 forwarded with tlast forced on beat 8, err_trunc pulsed once, beats 9..12 consumed with no output, then 15 flush beats.
5. Packet of exactly 8 beats with tlast on beat 8 (MAX_PKT = 8). Expect no err_trunc and normal flush.
6. reset pulsed low for 1 cycle after beat 2 of a 5-beat packet. Expect all outputs 0 immediately, and the next grant goes to channel 0 if it is requesting.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR input-stream arbiter and related blocks.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DROP  = 2'd2,
        FLUSH = 2'd3
    } arb_state_e;

    localparam int FIR_TAPS       = 15;
    localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: first requester after last_ptr, wrapping modulo N_CH.
// Purely combinational so other arbiters can reuse it.
module rr_priority_pick #(
    parameter int N_CH = 4,
    parameter int ID_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [ID_W-1:0] last_ptr,
    output logic [ID_W-1:0] pick_id,
    output logic            any_req
);

    logic [ID_W-1:0] idx_s;
    logic            found_s;

    // Scan all positions starting just after last_ptr; the first hit wins
    always_comb begin
        pick_id = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx_s = ID_W'((int'(last_ptr) + i) % N_CH);
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                pick_id = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fir_stream_arbiter.sv
// Per-packet round-robin arbiter feeding one FIR stream input, with zero-beat
// flushing between packets and a packet-length watchdog.
module fir_stream_arbiter
    import fir_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int FLUSH_LEN = FIR_TAPS,
    parameter int MAX_PKT   = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CH*DATA_W-1:0]    s_axis_tdata,
    input  logic [N_CH-1:0]           s_axis_tvalid,
    input  logic [N_CH-1:0]           s_axis_tlast,
    output logic [N_CH-1:0]           s_axis_tready,
    output logic [DATA_W-1:0]         m_axis_fir_tdata,
    output logic                      m_axis_fir_tvalid,
    output logic                      m_axis_fir_tlast,
    input  logic                      m_axis_fir_tready,
    output logic [$clog2(N_CH)-1:0]   m_axis_fir_tid,
    output logic                      m_axis_fir_tflush,
    output logic                      err_trunc
);

    localparam int ID_W   = $clog2(N_CH);
    localparam int BCNT_W = $clog2(MAX_PKT + 1);
    localparam int FCNT_W = $clog2(FLUSH_LEN + 1);

    arb_state_e        state_r, state_nxt_s;
    logic [ID_W-1:0]   grant_r, grant_nxt_s;
    logic [ID_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
    logic [BCNT_W-1:0] beat_cnt_r, beat_cnt_nxt_s;
    logic [FCNT_W-1:0] flush_cnt_r, flush_cnt_nxt_s;
    logic              err_trunc_r, trunc_s;
    logic [ID_W-1:0]   pick_id_s;
    logic              any_req_s;
    logic              at_limit_s;
    logic [DATA_W-1:0] ch_data_s [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign ch_data_s[g] = s_axis_tdata[g*DATA_W +: DATA_W];
    end

    rr_priority_pick #(
        .N_CH (N_CH),
        .ID_W (ID_W)
    ) u_pick (
        .req      (s_axis_tvalid),
        .last_ptr (rr_ptr_r),
        .pick_id  (pick_id_s),
        .any_req  (any_req_s)
    );

    // State, arbitration and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            rr_ptr_r    <= ID_W'(N_CH - 1);
            beat_cnt_r  <= '0;
            flush_cnt_r <= '0;
            err_trunc_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            grant_r     <= grant_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            beat_cnt_r  <= beat_cnt_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
            err_trunc_r <= trunc_s;
        end
    end

    // Next-state logic and output muxing; PASS is a zero-latency pass-through
    always_comb begin
        state_nxt_s       = state_r;
        grant_nxt_s       = grant_r;
        rr_ptr_nxt_s      = rr_ptr_r;
        beat_cnt_nxt_s    = beat_cnt_r;
        flush_cnt_nxt_s   = flush_cnt_r;
        trunc_s           = 1'b0;
        at_limit_s        = (beat_cnt_r == BCNT_W'(MAX_PKT - 1));
        s_axis_tready     = '0;
        m_axis_fir_tdata  = '0;
        m_axis_fir_tvalid = 1'b0;
        m_axis_fir_tlast  = 1'b0;
        m_axis_fir_tid    = '0;
        m_axis_fir_tflush = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    grant_nxt_s    = pick_id_s;
                    rr_ptr_nxt_s   = pick_id_s;
                    beat_cnt_nxt_s = '0;
                    state_nxt_s    = PASS;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            PASS: begin
                m_axis_fir_tdata       = ch_data_s[grant_r];
                m_axis_fir_tvalid      = s_axis_tvalid[grant_r];
                m_axis_fir_tlast       = s_axis_tlast[grant_r] | at_limit_s;
                m_axis_fir_tid         = grant_r;
                s_axis_tready[grant_r] = m_axis_fir_tready;
                if (s_axis_tvalid[grant_r] && m_axis_fir_tready) begin
                    beat_cnt_nxt_s = beat_cnt_r + BCNT_W'(1);
                    if (s_axis_tlast[grant_r]) begin
                        flush_cnt_nxt_s = '0;
                        state_nxt_s     = FLUSH;
                    end else if (at_limit_s) begin
                        trunc_s     = 1'b1;
                        state_nxt_s = DROP;
                    end else begin
                        state_nxt_s = PASS;
                    end
                end else begin
                    state_nxt_s = PASS;
                end
            end
            DROP: begin
                // Swallow the rest of a truncated packet without forwarding it
                s_axis_tready[grant_r] = 1'b1;
                if (s_axis_tvalid[grant_r] && s_axis_tlast[grant_r]) begin
                    flush_cnt_nxt_s = '0;
                    state_nxt_s     = FLUSH;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            FLUSH: begin
                m_axis_fir_tvalid = 1'b1;
                m_axis_fir_tflush = 1'b1;
                m_axis_fir_tid    = grant_r;
                if (m_axis_fir_tready) begin
                    if (flush_cnt_r == FCNT_W'(FLUSH_LEN - 1)) begin
                        flush_cnt_nxt_s = '0;
                        state_nxt_s     = IDLE;
                    end else begin
                        flush_cnt_nxt_s = flush_cnt_r + FCNT_W'(1);
                    end
                end else begin
                    flush_cnt_nxt_s = flush_cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign err_trunc = err_trunc_r;

endmodule

// File: tb/tb_fir_stream_arbiter.sv
// Directed bench for fir_stream_arbiter: collects every output transfer and
// compares it against hand-built expected beat lists.
`timescale 1ns/1ps
module tb_fir_stream_arbiter;

    localparam int N_CH = 4;
    localparam int DW   = 16;
    localparam int FL   = 15;
    localparam int MP   = 8;

    typedef struct packed {
        logic [1:0]    tid;
        logic [DW-1:0] data;
        logic          last;
        logic          flush;
    } beat_t;

    logic                 clk      = 1'b0;
    logic                 rst_n    = 1'b0;
    logic [N_CH*DW-1:0]   s_tdata;
    logic [N_CH-1:0]      s_tvalid;
    logic [N_CH-1:0]      s_tlast;
    logic [N_CH-1:0]      s_tready;
    logic [DW-1:0]        m_tdata;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic                 m_tready = 1'b1;
    logic [1:0]           m_tid;
    logic                 m_tflush;
    logic                 err_trunc;

    logic [DW-1:0] src_data  [N_CH];
    logic          src_valid [N_CH];
    logic          src_last  [N_CH];

    int    n_checks = 0;
    int    n_errors = 0;
    int    err_cnt  = 0;
    logic  rdy_mode = 1'b0;
    logic [3:0] rdy_pat = 4'b1001;
    int    rdy_ph   = 0;
    beat_t got_q[$];
    beat_t exp_q[$];
    beat_t cur;
    beat_t held_r;
    logic  stall_r = 1'b0;

    fir_stream_arbiter #(
        .N_CH      (N_CH),
        .DATA_W    (DW),
        .FLUSH_LEN (FL),
        .MAX_PKT   (MP)
    ) dut (
        .clk               (clk),
        .reset             (rst_n),
        .s_axis_tdata      (s_tdata),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tlast      (s_tlast),
        .s_axis_tready     (s_tready),
        .m_axis_fir_tdata  (m_tdata),
        .m_axis_fir_tvalid (m_tvalid),
        .m_axis_fir_tlast  (m_tlast),
        .m_axis_fir_tready (m_tready),
        .m_axis_fir_tid    (m_tid),
        .m_axis_fir_tflush (m_tflush),
        .err_trunc         (err_trunc)
    );

    always #5 clk = ~clk;

    always_comb begin
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        for (int i = 0; i < N_CH; i++) begin
            s_tdata[i*DW +: DW] = src_data[i];
            s_tvalid[i]         = src_valid[i];
            s_tlast[i]          = src_last[i];
        end
    end

    assign cur = {m_tid, m_tdata, m_tlast, m_tflush};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: record transfers, hold-stable check while stalled, count error pulses
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_r <= 1'b0;
        end else begin
            if (stall_r) begin
                check("stall_valid", {31'd0, m_tvalid}, 32'd1);
                check("stall_beat", {12'd0, cur}, {12'd0, held_r});
            end
            if (m_tvalid && m_tready) got_q.push_back(cur);
            stall_r <= m_tvalid && !m_tready;
            held_r  <= cur;
            if (err_trunc) err_cnt <= err_cnt + 1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                m_tready = rdy_pat[rdy_ph];
                rdy_ph   = (rdy_ph + 1) % 4;
            end else begin
                m_tready = 1'b1;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            src_valid[i] = 1'b0;
            src_last[i]  = 1'b0;
            src_data[i]  = 16'd0;
        end
        #1;
        check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_tready", {28'd0, s_tready}, 32'd0);
        check("rst_tdata",  {16'd0, m_tdata}, 32'd0);
        check("rst_tid",    {30'd0, m_tid}, 32'd0);
        check("rst_tflush", {31'd0, m_tflush}, 32'd0);
        check("rst_err",    {31'd0, err_trunc}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_xfer(input int ch);
        bit done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = s_tready[ch] && src_valid[ch];
            @(posedge clk);
            #1;
        end
        if (!done) check("xfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input int ch, input int len, input int base);
        for (int b = 1; b <= len; b++) begin
            src_valid[ch] = 1'b1;
            src_data[ch]  = 16'(base + b);
            src_last[ch]  = (b == len);
            wait_xfer(ch);
        end
        src_valid[ch] = 1'b0;
        src_last[ch]  = 1'b0;
        src_data[ch]  = 16'd0;
    endtask

    task automatic exp_pkt(input logic [1:0] tid, input int base, input int n);
        for (int b = 1; b <= n; b++) exp_q.push_back({tid, 16'(base + b), (b == n), 1'b0});
        for (int f = 0; f < FL; f++) exp_q.push_back({tid, 16'd0, 1'b0, 1'b1});
    endtask

    task automatic compare_all(input string tag);
        int n;
        for (int k = 0; k < 400 && got_q.size() < exp_q.size(); k++) @(posedge clk);
        @(negedge clk);
        check({tag, "_idle_valid"}, {31'd0, m_tvalid}, 32'd0);
        check({tag, "_idle_ready"}, {28'd0, s_tready}, 32'd0);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_beat%0d", tag, i), {12'd0, got_q[i]}, {12'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        // 1: single 4-beat packet on channel 0
        do_reset();
        send(0, 4, 0);
        exp_pkt(2'd0, 0, 4);
        compare_all("t1");

        // 2: round-robin order from reset, then wrap-around
        do_reset();
        fork
            send(1, 2, 10);
            send(3, 2, 30);
        join
        exp_pkt(2'd1, 10, 2);
        exp_pkt(2'd3, 30, 2);
        compare_all("t2a");
        fork
            send(0, 2, 40);
            send(1, 2, 50);
            send(3, 2, 60);
        join
        exp_pkt(2'd0, 40, 2);
        exp_pkt(2'd1, 50, 2);
        exp_pkt(2'd3, 60, 2);
        compare_all("t2b");

        // 3: back-pressure pattern 1,0,0,1 through PASS and FLUSH
        do_reset();
        rdy_ph   = 0;
        rdy_mode = 1'b1;
        send(0, 3, 70);
        exp_pkt(2'd0, 70, 3);
        compare_all("t3");
        rdy_mode = 1'b0;

        // 4: 12-beat packet truncated at 8 beats
        do_reset();
        e0 = err_cnt;
        send(2, 12, 100);
        exp_pkt(2'd2, 100, 8);
        compare_all("t4");
        check("t4_err_pulses", err_cnt - e0, 32'd1);

        // 5: exactly MAX_PKT beats with real tlast is a normal end
        do_reset();
        e0 = err_cnt;
        send(2, 8, 200);
        exp_pkt(2'd2, 200, 8);
        compare_all("t5");
        check("t5_err_pulses", err_cnt - e0, 32'd0);

        // 6: reset mid-packet clears outputs at once; channel 0 wins next
        do_reset();
        src_valid[0] = 1'b1;
        src_last[0]  = 1'b0;
        src_data[0]  = 16'd301;
        wait_xfer(0);
        src_data[0]  = 16'd302;
        wait_xfer(0);
        src_data[0]  = 16'd303;
        rst_n = 1'b0;
        #1;
        check("t6_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("t6_tready", {28'd0, s_tready}, 32'd0);
        check("t6_tdata",  {16'd0, m_tdata}, 32'd0);
        check("t6_tlast",  {31'd0, m_tlast}, 32'd0);
        check("t6_tid",    {30'd0, m_tid}, 32'd0);
        check("t6_tflush", {31'd0, m_tflush}, 32'd0);
        src_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        fork
            send(0, 2, 400);
            send(1, 1, 500);
        join
        exp_pkt(2'd0, 400, 2);
        exp_pkt(2'd1, 500, 1);
        compare_all("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
